// File: rtl/switch_conditioner.sv
// Input conditioning for the two-switch hazard-light FSM: per-bit synchronizer
// and debouncer, rising-edge pulses, and a step prescaler restarted on any switch change.
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_CYCLES      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw,
  output logic [1:0] sw_rise,
  output logic       step
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(DIV_CYCLES - 1);

  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    w_sw;
  logic [1:0]    w_rise;
  logic [1:0]    w_upd;
  logic          w_change;
  logic [PW-1:0] r_pcnt;
  logic          r_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bit
      logic          r_sw;
      logic          r_rise;
      logic [CW-1:0] r_cnt;

      // sw flips on the edge where the mismatch has already been seen DEBOUNCE_CYCLES-1 times
      assign w_upd[gi] = (r_s2[gi] != r_sw) && (r_cnt == DB_LAST);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sw   <= 1'b0;
          r_rise <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_rise <= w_upd[gi] & r_s2[gi];
          if (r_s2[gi] == r_sw) begin
            r_cnt <= '0;
          end else if (w_upd[gi]) begin
            r_sw  <= r_s2[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      assign w_sw[gi]   = r_sw;
      assign w_rise[gi] = r_rise;
    end
  endgenerate

  assign w_change = |w_upd;

  // A switch change restarts the period and overrides a coincident wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
      r_step <= 1'b0;
    end else if (w_change) begin
      r_pcnt <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= (r_pcnt == P_LAST);
      r_pcnt <= (r_pcnt == P_LAST) ? '0 : r_pcnt + PW'(1);
    end
  end

  assign sw      = w_sw;
  assign sw_rise = w_rise;
  assign step    = r_step;

endmodule
